alu_frame_sequencer: RTL and testbench
======================================

ALU_FRAME_SEQUENCER -- requirements
Module: alu_frame_sequencer

Interface
REQ-001 SHALL have parameters: BUS_SIZE, 8, data/operand width; NB_OP, 6, opcode width; TIMEOUT_CYCLES, 50000, maximum idle cycles between bytes of one frame.
REQ-002 SHALL have ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset; asynchronous, active-high.
- i_rx_data  in  BUS_SIZE  RX FIFO head byte, valid while i_rx_empty=0.
- i_rx_empty  in  1  RX FIFO empty.
- o_rd_uart  out  1  RX FIFO pop strobe.
- o_tx_data  out  BUS_SIZE  TX FIFO write data.
- i_tx_full  in  1  TX FIFO full.
- o_wr_uart  out  1  TX FIFO push strobe.
- o_alu_a, o_alu_b  out  BUS_SIZE  registered ALU operands.
- o_alu_op  out  NB_OP  registered ALU opcode.
- i_alu_result  in  BUS_SIZE  combinational ALU result.
- i_alu_carry  in  1  ALU carry.
- o_result  out  BUS_SIZE  last captured result.
- o_carry  out  1  last captured carry.
- o_busy  out  1  high in every state except GET_A.
- o_timeout  out  1  one-cycle pulse on frame abort.
- o_err_count  out  8  saturating count of aborted frames.

Function
REQ-003 SHALL implement FSM GET_A -> GET_B -> GET_OP -> EXEC -> SEND_RES -> SEND_FLG -> GET_A.
REQ-004 In GET_A/GET_B/GET_OP, o_rd_uart SHALL equal ~i_rx_empty (combinational); on that edge the byte is captured into o_alu_a / o_alu_b / o_alu_op (low NB_OP bits, upper bits ignored) and the state advances.
REQ-005 o_rd_uart SHALL be 0 in EXEC, SEND_RES, SEND_FLG regardless of i_rx_empty.
REQ-006 EXEC SHALL last exactly one cycle; at its closing edge i_alu_result -> o_result, i_alu_carry -> o_carry, zero flag = (i_alu_result==0) registered.
REQ-007 In SEND_RES, o_tx_data SHALL be o_result and o_wr_uart = ~i_tx_full; advance to SEND_FLG only on a write.
REQ-008 In SEND_FLG, o_tx_data SHALL be status byte {zeros, zero, carry} (bit0 carry, bit1 zero) and o_wr_uart = ~i_tx_full; advance to GET_A only on a write.
REQ-009 Latency: first o_wr_uart SHALL assert two cycles after the cycle in which the opcode byte is popped, provided i_tx_full=0.
REQ-010 While i_tx_full=1 the FSM SHALL hold state with o_wr_uart=0 indefinitely (no timeout in send states).
REQ-011 Timeout counter SHALL clear on every accepted byte and in GET_A, and increment each cycle in GET_B/GET_OP with i_rx_empty=1.
REQ-012 When the counter reaches TIMEOUT_CYCLES-1 the FSM SHALL return to GET_A, pulse o_timeout one cycle, increment o_err_count (saturate at 255), and discard partial operands (o_alu_* retain values, no TX write).
REQ-013 If a byte arrives in the same cycle the counter reaches terminal count, the byte SHALL be accepted and the timeout suppressed.
REQ-014 Back-to-back frames with RX never empty SHALL be processed with no lost or duplicated bytes.

Reset
REQ-015 On i_reset: state GET_A; o_alu_a, o_alu_b, o_alu_op, o_result, o_carry, zero flag, counter, o_err_count = 0; o_timeout, o_busy, o_rd_uart, o_wr_uart = 0.
REQ-016 Reset mid-frame or mid-send SHALL abandon the frame with no further TX write and no o_err_count change.

Structure
REQ-017 Package alu_uart_pkg SHALL hold state encoding, status-byte bit positions, and default TIMEOUT_CYCLES.
REQ-018 The idle counter SHALL be sub-module frame_timeout_counter (clear, enable, terminal-count out).

Verification (bench ALU model: op 0x20 = ADD)
REQ-019 RX 0x05,0x03,0x20 -> TX 0x08 then 0x00; o_result=0x08, o_carry=0.
REQ-020 RX 0xFF,0x01,0x20 -> TX 0x00 then 0x03; o_carry=1.
REQ-021 RX 0x05 then silence TIMEOUT_CYCLES -> one o_timeout pulse, o_err_count=1, no TX; then 0x01,0x02,0x20 -> TX 0x03, 0x00.
REQ-022 i_tx_full=1 for 10 cycles on SEND_RES entry with RX non-empty -> o_wr_uart=0 and o_rd_uart=0 throughout; result written on the first cycle after release.
REQ-023 Six bytes queued (0x01,0x01,0x20,0x02,0x02,0x20) -> TX 0x02,0x00,0x04,0x00 in order, exactly six pops.
REQ-024 i_reset asserted after 0x07,0x08 popped -> state GET_A, all outputs 0, no TX write.

Source files
------------

// File: rtl/alu_frame_sequencer_pkg.sv
// Shared definitions for the ALU frame sequencer: FSM state encoding,
// status-byte bit positions and the default inter-byte idle limit.
package alu_uart_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 50000;

  // Status byte layout sent after each result byte
  localparam int unsigned STATUS_CARRY_BIT = 0;
  localparam int unsigned STATUS_ZERO_BIT  = 1;

  typedef enum logic [2:0] {
    ST_GET_A    = 3'd0,
    ST_GET_B    = 3'd1,
    ST_GET_OP   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SEND_RES = 3'd4,
    ST_SEND_FLG = 3'd5
  } state_t;

endpackage

// File: rtl/alu_frame_sequencer_if.sv
// UART FIFO handshake bundle between the sequencer and its RX/TX FIFOs.
//   i_rx_data/i_rx_empty : RX FIFO head byte and empty flag
//   o_rd_uart            : RX FIFO pop strobe
//   o_tx_data/o_wr_uart  : TX FIFO write data and push strobe
//   i_tx_full            : TX FIFO full flag
// slave = sequencer side, master = FIFO/environment side.
interface alu_frame_sequencer_if #(
  parameter int unsigned BUS_SIZE = 8
);
  logic [BUS_SIZE-1:0] i_rx_data;
  logic                i_rx_empty;
  logic                o_rd_uart;
  logic [BUS_SIZE-1:0] o_tx_data;
  logic                i_tx_full;
  logic                o_wr_uart;

  modport master (
    output i_rx_data, i_rx_empty, i_tx_full,
    input  o_rd_uart, o_tx_data, o_wr_uart
  );

  modport slave (
    input  i_rx_data, i_rx_empty, i_tx_full,
    output o_rd_uart, o_tx_data, o_wr_uart
  );
endinterface

// File: rtl/alu_frame_sequencer_timeout.sv
// Idle-cycle counter used to abort stalled frames.
//   i_clock/i_reset : clock, async active-high reset
//   clear_i         : synchronous clear (wins over enable)
//   enable_i        : count one idle cycle
//   tc_o            : counter sits at TIMEOUT_CYCLES-1
module frame_timeout_counter
  import alu_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tc_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/alu_frame_sequencer.sv
// Collects A, B and opcode bytes from the RX FIFO, latches the external
// ALU result for one cycle, then writes result and status bytes to TX.
//   i_clock/i_reset      : clock, async active-high reset
//   fifo_if (slave)      : RX/TX FIFO handshake
//   o_alu_a/b/op         : registered ALU operands and opcode
//   i_alu_result/carry   : combinational ALU outputs
//   o_result/o_carry     : last captured result and carry
//   o_busy               : high outside GET_A
//   o_timeout            : one-cycle pulse on frame abort
//   o_err_count          : saturating aborted-frame count
module alu_frame_sequencer
  import alu_uart_pkg::*;
#(
  parameter int unsigned BUS_SIZE       = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  alu_frame_sequencer_if.slave  fifo_if,
  output logic [BUS_SIZE-1:0]   o_alu_a,
  output logic [BUS_SIZE-1:0]   o_alu_b,
  output logic [NB_OP-1:0]      o_alu_op,
  input  logic [BUS_SIZE-1:0]   i_alu_result,
  input  logic                  i_alu_carry,
  output logic [BUS_SIZE-1:0]   o_result,
  output logic                  o_carry,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic [7:0]            o_err_count
);
  state_t              state_q;
  logic [BUS_SIZE-1:0] alu_a_q, alu_b_q, result_q;
  logic [NB_OP-1:0]    alu_op_q;
  logic                carry_q, zero_q, timeout_q;
  logic [7:0]          err_count_q;

  logic                in_get_c, in_send_c, wait_byte_c;
  logic                rx_accept_c, tx_accept_c, abort_c, cnt_clear_c, tc_c;
  logic [BUS_SIZE-1:0] status_c;

  // Handshake decode; strobes are forced low while reset is asserted
  always_comb begin
    in_get_c    = (state_q == ST_GET_A) || (state_q == ST_GET_B) || (state_q == ST_GET_OP);
    in_send_c   = (state_q == ST_SEND_RES) || (state_q == ST_SEND_FLG);
    rx_accept_c = in_get_c && !fifo_if.i_rx_empty && !i_reset;
    tx_accept_c = in_send_c && !fifo_if.i_tx_full && !i_reset;
    wait_byte_c = ((state_q == ST_GET_B) || (state_q == ST_GET_OP)) && fifo_if.i_rx_empty;
    // An arriving byte at terminal count is accepted, so abort needs RX empty
    abort_c     = wait_byte_c && tc_c;
    cnt_clear_c = rx_accept_c || (state_q == ST_GET_A) || abort_c;
    status_c                   = '0;
    status_c[STATUS_CARRY_BIT] = carry_q;
    status_c[STATUS_ZERO_BIT]  = zero_q;
  end

  frame_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .clear_i  (cnt_clear_c),
    .enable_i (wait_byte_c),
    .tc_o     (tc_c)
  );

  // Frame FSM and all registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_GET_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      timeout_q <= abort_c;
      if (abort_c && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      case (state_q)
        ST_GET_A: begin
          if (rx_accept_c) begin
            alu_a_q <= fifo_if.i_rx_data;
            state_q <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (rx_accept_c) begin
            alu_b_q <= fifo_if.i_rx_data;
            state_q <= ST_GET_OP;
          end else if (abort_c) begin
            state_q <= ST_GET_A;
          end
        end
        ST_GET_OP: begin
          if (rx_accept_c) begin
            alu_op_q <= fifo_if.i_rx_data[NB_OP-1:0];
            state_q  <= ST_EXEC;
          end else if (abort_c) begin
            state_q <= ST_GET_A;
          end
        end
        ST_EXEC: begin
          result_q <= i_alu_result;
          carry_q  <= i_alu_carry;
          zero_q   <= (i_alu_result == '0);
          state_q  <= ST_SEND_RES;
        end
        ST_SEND_RES: begin
          if (tx_accept_c) begin
            state_q <= ST_SEND_FLG;
          end
        end
        ST_SEND_FLG: begin
          if (tx_accept_c) begin
            state_q <= ST_GET_A;
          end
        end
        default: state_q <= ST_GET_A;
      endcase
    end
  end

  assign fifo_if.o_rd_uart = rx_accept_c;
  assign fifo_if.o_wr_uart = tx_accept_c;
  assign fifo_if.o_tx_data = (state_q == ST_SEND_FLG) ? status_c : result_q;

  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_result    = result_q;
  assign o_carry     = carry_q;
  assign o_busy      = (state_q != ST_GET_A);
  assign o_timeout   = timeout_q;
  assign o_err_count = err_count_q;
endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Self-checking bench for alu_frame_sequencer: RX/TX FIFO models, an
// environment ALU, and a frame-level reference of the expected TX stream.
module tb_alu_frame_sequencer;
  localparam int unsigned BUS_SIZE = 8;
  localparam int unsigned NB_OP    = 6;
  localparam int unsigned TO       = 8;

  logic clk = 1'b0;
  logic rst;

  alu_frame_sequencer_if #(.BUS_SIZE(BUS_SIZE)) fifo_if ();

  logic [7:0] alu_a, alu_b, alu_result, result, err_count;
  logic [5:0] alu_op;
  logic       alu_carry, carry, busy, timeout;

  alu_frame_sequencer #(
    .BUS_SIZE       (BUS_SIZE),
    .NB_OP          (NB_OP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .fifo_if      (fifo_if.slave),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_result),
    .i_alu_carry  (alu_carry),
    .o_result     (result),
    .o_carry      (carry),
    .o_busy       (busy),
    .o_timeout    (timeout),
    .o_err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Environment ALU (0x20 = ADD); bit 8 is carry/borrow
  function automatic logic [8:0] alu_env(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return {1'b0, a} + {1'b0, b};
      6'h22:   return {1'b0, a} - {1'b0, b};
      6'h24:   return {1'b0, a & b};
      6'h25:   return {1'b0, a | b};
      6'h26:   return {1'b0, a ^ b};
      6'h27:   return {1'b0, ~(a | b)};
      default: return 9'h000;
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_env(alu_a, alu_b, alu_op);

  // RX FIFO model: bench appends, DUT pops
  logic [7:0] rx_mem [0:1023];
  int         rx_wr = 0;
  int         pops  = 0;
  assign fifo_if.i_rx_data  = rx_mem[pops];
  assign fifo_if.i_rx_empty = (pops == rx_wr);

  logic tx_full;
  assign fifo_if.i_tx_full = tx_full;

  // Observed events, time-stamped in clock edges
  int         cyc = 0, tx_cnt = 0, to_cnt = 0, to_cyc = 0;
  int         pop_cyc [0:1023];
  int         wr_cyc  [0:511];
  logic [7:0] tx_got  [0:511];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_if.o_rd_uart) begin
      pop_cyc[pops] <= cyc;
      pops          <= pops + 1;
    end
    if (fifo_if.o_wr_uart) begin
      tx_got[tx_cnt] <= fifo_if.o_tx_data;
      wr_cyc[tx_cnt] <= cyc;
      tx_cnt         <= tx_cnt + 1;
    end
    if (timeout) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  // Reference: expected TX byte stream per completed frame
  logic [7:0] exp_tx [0:511];
  int         exp_cnt = 0;
  int         chk_idx = 0;
  logic [7:0] exp_res;
  logic       exp_carry;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic ref_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte);
    logic [8:0] r;
    r = alu_env(a, b, op_byte[5:0]);
    exp_tx[exp_cnt]     = r[7:0];
    exp_tx[exp_cnt + 1] = {6'b0, (r[7:0] == 8'h00), r[8]};
    exp_cnt  += 2;
    exp_res   = r[7:0];
    exp_carry = r[8];
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte);
    push(a);
    push(b);
    push(op_byte);
    ref_frame(a, b, op_byte);
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (pops < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pop_wait", 32'(pops >= n), 32'd1);
  endtask

  // Wait for all queued frames to leave TX, then compare the stream
  task automatic drain(input string tag, input bit rand_full);
    int k = 0;
    while ((tx_cnt < exp_cnt || pops != rx_wr || busy) && k < 3000) begin
      @(negedge clk);
      if (rand_full) tx_full = ($urandom_range(0, 3) == 0);
      k++;
    end
    tx_full = 1'b0;
    chk({tag, "_drain"}, 32'(k < 3000), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_txcount"}, 32'(tx_cnt), 32'(exp_cnt));
    for (int i = chk_idx; i < exp_cnt; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), 32'(tx_got[i]), 32'(exp_tx[i]));
    end
    chk_idx = exp_cnt;
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_carry"}, 32'(carry), 32'(exp_carry));
  endtask

  initial begin
    int base_p, base_tx, base_to, exp_err;
    logic [5:0] ops [0:5];
    ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24;
    ops[3] = 6'h25; ops[4] = 6'h26; ops[5] = 6'h27;

    rst = 1'b1;
    tx_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_rd", 32'(fifo_if.o_rd_uart), 32'd0);
    chk("rst_wr", 32'(fifo_if.o_wr_uart), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD without carry, plus pop-to-write latency
    send_frame(8'h05, 8'h03, 8'h20);
    drain("add", 1'b0);
    chk("add_lit_res", 32'(tx_got[0]), 32'h08);
    chk("add_lit_flg", 32'(tx_got[1]), 32'h00);
    chk("add_latency", 32'(wr_cyc[0] - pop_cyc[2]), 32'd2);
    chk("idle_busy", 32'(busy), 32'd0);

    // ADD with carry-out and zero result
    send_frame(8'hFF, 8'h01, 8'h20);
    drain("carry", 1'b0);
    chk("carry_lit_res", 32'(tx_got[2]), 32'h00);
    chk("carry_lit_flg", 32'(tx_got[3]), 32'h03);
    chk("carry_latency", 32'(wr_cyc[2] - pop_cyc[5]), 32'd2);

    // Silence after the A byte aborts the frame
    base_to = to_cnt; base_tx = tx_cnt; base_p = pops;
    push(8'h05);
    repeat (TO + 6) @(negedge clk);
    chk("to_pulses", 32'(to_cnt), 32'(base_to + 1));
    chk("to_cycle", 32'(to_cyc - pop_cyc[base_p]), 32'(TO + 1));
    chk("to_err", 32'(err_count), 32'd1);
    chk("to_no_tx", 32'(tx_cnt), 32'(base_tx));
    chk("to_keep_a", 32'(alu_a), 32'h05);
    chk("to_keep_b", 32'(alu_b), 32'h01);
    chk("to_busy", 32'(busy), 32'd0);
    send_frame(8'h01, 8'h02, 8'h20);
    drain("after_to", 1'b0);
    chk("after_to_lit_res", 32'(tx_got[4]), 32'h03);
    chk("after_to_lit_flg", 32'(tx_got[5]), 32'h00);

    // Byte arriving exactly at terminal count is taken, no abort
    base_to = to_cnt;
    push(8'h09);
    @(negedge clk);
    chk("tc_in_get_b", 32'(busy), 32'd1);
    repeat (TO - 1) @(negedge clk);
    push(8'h04);
    push(8'h20);
    ref_frame(8'h09, 8'h04, 8'h20);
    drain("tc_edge", 1'b0);
    chk("tc_no_pulse", 32'(to_cnt), 32'(base_to));
    chk("tc_err", 32'(err_count), 32'd1);

    // TX full on SEND_RES entry with RX still holding the next frame
    tx_full = 1'b1;
    base_p = pops; base_tx = tx_cnt; base_to = to_cnt;
    send_frame(8'h10, 8'h20, 8'h20);
    send_frame(8'h30, 8'h05, 8'h22);
    wait_pops(base_p + 3);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("stall_wr%0d", i), 32'(fifo_if.o_wr_uart), 32'd0);
      chk($sformatf("stall_rd%0d", i), 32'(fifo_if.o_rd_uart), 32'd0);
      @(negedge clk);
    end
    chk("stall_pops", 32'(pops), 32'(base_p + 3));
    chk("stall_no_tx", 32'(tx_cnt), 32'(base_tx));
    chk("stall_no_to", 32'(to_cnt), 32'(base_to));
    tx_full = 1'b0;
    @(negedge clk);
    chk("release_tx", 32'(tx_cnt), 32'(base_tx + 1));
    chk("release_byte", 32'(tx_got[base_tx]), 32'h30);
    drain("stall", 1'b0);

    // Two frames queued back-to-back
    base_p = pops; base_tx = tx_cnt;
    send_frame(8'h01, 8'h01, 8'h20);
    send_frame(8'h02, 8'h02, 8'h20);
    drain("b2b", 1'b0);
    chk("b2b_pops", 32'(pops - base_p), 32'd6);
    chk("b2b_lit0", 32'(tx_got[base_tx]), 32'h02);
    chk("b2b_lit1", 32'(tx_got[base_tx + 1]), 32'h00);
    chk("b2b_lit2", 32'(tx_got[base_tx + 2]), 32'h04);
    chk("b2b_lit3", 32'(tx_got[base_tx + 3]), 32'h00);

    // Random frames, random opcode upper bits, random TX back-pressure
    for (int i = 0; i < 20; i++) begin
      send_frame(8'($urandom), 8'($urandom),
                 {2'($urandom), ops[$urandom_range(0, 5)]});
    end
    drain("rand", 1'b1);

    // Repeated aborts in GET_B and GET_OP; error count saturates
    for (int i = 0; i < 260; i++) begin
      base_to = to_cnt;
      push(8'h11);
      if (i % 2 == 1) push(8'h22);
      for (int k = 0; k < 4 * TO && to_cnt == base_to; k++) @(negedge clk);
      exp_err = (i + 2 > 255) ? 255 : i + 2;
      chk($sformatf("sat_err%0d", i), 32'(err_count), 32'(exp_err));
    end
    chk("sat_no_tx", 32'(tx_cnt), 32'(exp_cnt));

    // Reset mid-frame abandons it without TX or error count
    base_p = pops; base_tx = tx_cnt;
    push(8'h07);
    push(8'h08);
    wait_pops(base_p + 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_carry", 32'(carry), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    chk("mid_rst_timeout", 32'(timeout), 32'd0);
    chk("mid_rst_txdata", 32'(fifo_if.o_tx_data), 32'd0);
    push(8'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_rd%0d", i), 32'(fifo_if.o_rd_uart), 32'd0);
      chk($sformatf("mid_rst_wr%0d", i), 32'(fifo_if.o_wr_uart), 32'd0);
    end
    chk("mid_rst_pops", 32'(pops), 32'(base_p + 2));
    chk("mid_rst_no_tx", 32'(tx_cnt), 32'(base_tx));
    rst = 1'b0;
    push(8'h01);
    push(8'h20);
    ref_frame(8'h55, 8'h01, 8'h20);
    drain("post_rst", 1'b0);
    chk("post_rst_lit", 32'(tx_got[base_tx]), 32'h56);
    chk("post_rst_err", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
